// File: rtl/flofifo_pkg.sv
// flofifo_pkg: shared widths, defaults and parameter sanity helpers for the
// flofifo_ext buffer and its interface.
package flofifo_pkg;

   localparam int DEF_LENGTH = 32;
   localparam int DEF_WIDTH  = 32;

   // Pointer width: indexes LENGTH words, wraps naturally for powers of two.
   function automatic int ptr_w(input int len);
      return (len > 1) ? $clog2(len) : 1;
   endfunction

   // Level width: must hold 0..LENGTH inclusive, hence LENGTH+1 codes.
   function automatic int lvl_w(input int len);
      return $clog2(len + 1);
   endfunction

   // Depth must be a power of two and at least 4.
   function automatic bit len_ok(input int len);
      return (len >= 4) && ((len & (len - 1)) == 0);
   endfunction

   // Thresholds must satisfy 0 <= AE_LEVEL < AF_LEVEL <= LENGTH.
   function automatic bit thr_ok(input int len, input int ae, input int af);
      return (ae >= 0) && (ae < af) && (af <= len);
   endfunction

endpackage

// File: rtl/flofifo_if.sv
// flofifo_if: producer/consumer side signals of the FIFO. The FIFO itself
// uses the slave view; whoever feeds and drains it uses the master view.
interface flofifo_if
   import flofifo_pkg::*;
#(
   parameter int LENGTH = DEF_LENGTH,
   parameter int WIDTH  = DEF_WIDTH
);
   localparam int LW = lvl_w(LENGTH);

   logic             clear_i;
   logic             err_clr_i;
   logic [WIDTH-1:0] data_i;
   logic             valid_i;
   logic             read_i;
   logic [WIDTH-1:0] data_o;
   logic             valid_o;
   logic [LW-1:0]    level_o;
   logic             empty_o;
   logic             full_o;
   logic             almost_full_o;
   logic             almost_empty_o;
   logic             overflow_o;
   logic             underflow_o;

   modport slave (
      input  clear_i, err_clr_i, data_i, valid_i, read_i,
      output data_o, valid_o, level_o, empty_o, full_o,
             almost_full_o, almost_empty_o, overflow_o, underflow_o
   );

   modport master (
      output clear_i, err_clr_i, data_i, valid_i, read_i,
      input  data_o, valid_o, level_o, empty_o, full_o,
             almost_full_o, almost_empty_o, overflow_o, underflow_o
   );

endinterface

// File: rtl/flofifo_ram.sv
// flofifo_ram: simple dual-port storage, one write port and one registered
// read port. The array has no reset so it maps onto block RAM; only the read
// output register is reset.
module flofifo_ram
   import flofifo_pkg::*;
#(
   parameter  int WIDTH  = DEF_WIDTH,
   parameter  int LENGTH = DEF_LENGTH,
   localparam int AW     = ptr_w(LENGTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_mem [LENGTH];
   logic [WIDTH-1:0] r_q;

   // Write port: store the incoming word at the write address.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Read port: registered, read-before-write on an address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       r_q <= '0;
      else if (i_re) r_q <= r_mem[i_raddr];
   end

   assign o_q = r_q;

endmodule

// File: rtl/flofifo_ext.sv
// flofifo_ext: buffered FIFO with exact fill level, programmable almost
// thresholds, sticky overflow/underflow, synchronous flush and an optional
// first-word-fall-through output.
module flofifo_ext
   import flofifo_pkg::*;
#(
   parameter int LENGTH   = DEF_LENGTH,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int FWFT     = 0,
   parameter int AF_LEVEL = LENGTH - 4,
   parameter int AE_LEVEL = 4
) (
   input  logic     clk,
   input  logic     rst,
   flofifo_if.slave bus
);

   localparam int            PW     = ptr_w(LENGTH);
   localparam int            LW     = lvl_w(LENGTH);
   localparam logic [LW-1:0] LVL_MX = LW'(LENGTH);
   localparam logic [LW-1:0] LVL_AF = LW'(AF_LEVEL);
   localparam logic [LW-1:0] LVL_AE = LW'(AE_LEVEL);

   if (!len_ok(LENGTH) || !thr_ok(LENGTH, AE_LEVEL, AF_LEVEL)) begin : g_bad_param
      $error("flofifo_ext: LENGTH or AE_LEVEL/AF_LEVEL out of range");
   end

   logic [PW-1:0]    r_wptr, r_rptr;
   logic [LW-1:0]    r_level, w_level_next;
   logic             r_empty, r_full, r_afull, r_aempty, r_ovf, r_udf;
   logic             w_wr_acc, w_rd_acc, w_ovf_set, w_udf_set;
   logic             w_re;
   logic [PW-1:0]    w_raddr;
   logic [WIDTH-1:0] w_ram_q;

   // Accept/reject decisions and next fill level; a flush overrides everything.
   always_comb begin
      w_rd_acc     = bus.read_i && !r_empty && !bus.clear_i;
      w_wr_acc     = bus.valid_i && (!r_full || w_rd_acc) && !bus.clear_i;
      w_ovf_set    = bus.valid_i && !w_wr_acc && !bus.clear_i;
      w_udf_set    = bus.read_i && r_empty && !bus.clear_i;
      w_level_next = r_level;
      if (bus.clear_i)              w_level_next = '0;
      else if (w_wr_acc && !w_rd_acc) w_level_next = r_level + LW'(1);
      else if (!w_wr_acc && w_rd_acc) w_level_next = r_level - LW'(1);
   end

   // Pointers, level counter, registered status and sticky error flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_level  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
         r_afull  <= 1'b0;
         r_aempty <= 1'b1;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         if (bus.clear_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_wr_acc) r_wptr <= r_wptr + PW'(1);
            if (w_rd_acc) r_rptr <= r_rptr + PW'(1);
         end
         r_level  <= w_level_next;
         r_empty  <= (w_level_next == '0);
         r_full   <= (w_level_next == LVL_MX);
         r_afull  <= (w_level_next >= LVL_AF);
         r_aempty <= (w_level_next <= LVL_AE);
         r_ovf    <= w_ovf_set || (r_ovf && !bus.err_clr_i);
         r_udf    <= w_udf_set || (r_udf && !bus.err_clr_i);
      end
   end

   flofifo_ram #(
      .WIDTH  (WIDTH),
      .LENGTH (LENGTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_wr_acc),
      .i_waddr (r_wptr),
      .i_wdata (bus.data_i),
      .i_re    (w_re),
      .i_raddr (w_raddr),
      .o_q     (w_ram_q)
   );

   if (FWFT == 0) begin : g_std
      logic r_valid;

      assign w_re    = w_rd_acc;
      assign w_raddr = r_rptr;

      // One-cycle valid pulse following each accepted pop.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) r_valid <= 1'b0;
         else     r_valid <= w_rd_acc;
      end

      assign bus.data_o  = w_ram_q;
      assign bus.valid_o = r_valid;
   end else begin : g_fwft
      logic             r_byp_sel;
      logic [WIDTH-1:0] r_byp_data;

      // The RAM continuously prefetches the word that will be at the head
      // after this cycle's pop, so the head is always on the read register.
      assign w_re    = 1'b1;
      assign w_raddr = bus.clear_i ? '0 : (w_rd_acc ? r_rptr + PW'(1) : r_rptr);

      // A word written to the address being prefetched is missed by the
      // read-before-write RAM for one cycle; capture it here instead.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_byp_sel  <= 1'b0;
            r_byp_data <= '0;
         end else if (w_wr_acc && (r_wptr == w_raddr)) begin
            r_byp_sel  <= 1'b1;
            r_byp_data <= bus.data_i;
         end else begin
            r_byp_sel  <= 1'b0;
         end
      end

      assign bus.data_o  = r_byp_sel ? r_byp_data : w_ram_q;
      assign bus.valid_o = !r_empty;
   end

   assign bus.level_o        = r_level;
   assign bus.empty_o        = r_empty;
   assign bus.full_o         = r_full;
   assign bus.almost_full_o  = r_afull;
   assign bus.almost_empty_o = r_aempty;
   assign bus.overflow_o     = r_ovf;
   assign bus.underflow_o    = r_udf;

endmodule
